gfifo_control: RTL and testbench
================================

Name: gfifo_control

Overview:
- Bridges the per-cycle difftest commit-step count from the simulated SoC to a host-side checker.
- Step counts are queued in an internal FIFO and drained over a valid/ready request channel to the host.
- Host verdicts return on a response channel and are folded into a sticky failure flag, simv_result.
- Sits in the emulation top beside the DUT and replaces the per-cycle software step call.

Parameters:
- STEP_WIDTH, 8: width of the step count per cycle.
- DEPTH, 16: FIFO entries, power of two, at least 2.
- MAX_OUTSTANDING, 4: maximum requests sent to the host without a response.

Ports:
- clock  in  1: sole clock; all logic on the rising edge.
- reset  in  1: synchronous, active-low reset (0 = reset asserted).
- step  in  STEP_WIDTH: commits this cycle; 0 means no request.
- simv_result  out  1: sticky failure flag; 1 = difftest failed or protocol error.
- host_req_valid  out  1: a queued step count is offered to the host.
- host_req_step  out  STEP_WIDTH: step count at the FIFO head.
- host_req_ready  in  1: host accepts the request on valid & ready.
- host_resp_valid  in  1: host returns one verdict this cycle.
- host_resp_fail  in  1: verdict; 1 = mismatch, qualified by host_resp_valid.
- fifo_count  out  $clog2(DEPTH)+1: current occupancy, for debug.

Behaviour:
- Reset (reset==0 at a clock edge) sets simv_result=0, host_req_valid=0, fifo_count=0, outstanding=0, overflow=0. FIFO contents are don't-care.
- Push: when step!=0, the value is written at the tail and count increments at the next edge. step==0 never pushes.
- Full FIFO on push: the entry is dropped, overflow is set, and simv_result=1 from the next cycle.
- Pop:
  - host_req_valid = (count!=0) & (outstanding<MAX_OUTSTANDING) & !simv_result.
  - host_req_step = head entry, shown combinationally from the FIFO, so an empty-to-non-empty transition gives 1-cycle latency from step to host_req_valid.
  - valid & ready pops the head and increments outstanding.
- Push and pop in the same cycle: count is unchanged. This holds even when full: the pop frees a slot, no overflow occurs, and the write lands in the freed slot.
- Response:
  - host_resp_valid decrements outstanding.
  - If host_resp_fail=1, simv_result=1 on the next edge.
  - A response arriving while outstanding==0 is a protocol error and also sets simv_result.
  - Request and response in the same cycle leave outstanding unchanged.
- simv_result is registered and sticky until reset; once set, no further requests are issued, while pushes continue to be counted.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from the count.
- Reset mid-transfer discards all queued and outstanding state; responses are not counted during reset.

Optional Feature:
- GFIFO_STAT_EN defined: adds output stat_total_steps (64 bits, reset 0).
  - It accumulates every nonzero step actually pushed; dropped entries are excluded.
  - The add is zero-extended and wraps at 2^64.
  - Also adds output stat_requests (32 bits), counting accepted host requests.
- GFIFO_STAT_EN undefined: these ports and their logic are absent.

Test Plan:
- Reset: reset=0 for 3 cycles with step=5 -> simv_result=0, fifo_count=0, host_req_valid=0 throughout.
- Single step: step=3 for one cycle, host_req_ready=1 -> next cycle host_req_valid=1 with host_req_step=3; popped; then a response with fail=0 -> simv_result stays 0, outstanding returns to 0.
- Backpressure: host_req_ready=0 and step=1..16 over 16 cycles -> fifo_count=16. A 17th step=9 sets simv_result=1 on the next cycle, and host_req_valid drops to 0.
- Outstanding limit: ready=1 with no responses, 6 queued steps -> exactly 4 requests accepted, fifo_count=2. One pass response -> a 5th request is issued.
- Failure: a response with fail=1 -> simv_result=1 next cycle and stays 1 until reset=0, after which it reads 0.
- Full with simultaneous push/pop: FIFO full, ready=1, step=7 -> no overflow, count stays 16, and 7 is later observed at the head in order.

Source files
------------

// File: rtl/gfifo_control.sv
// Difftest step bridge: queues per-cycle commit counts, drains them to the host
// over valid/ready, folds host verdicts into sticky simv_result. Optional GFIFO_STAT_EN.
module gfifo_control #(
  parameter int STEP_WIDTH      = 8,
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [STEP_WIDTH-1:0]   step,
  output logic                    simv_result,
  output logic                    host_req_valid,
  output logic [STEP_WIDTH-1:0]   host_req_step,
  input  logic                    host_req_ready,
  input  logic                    host_resp_valid,
  input  logic                    host_resp_fail,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef GFIFO_STAT_EN
  ,output logic [63:0]            stat_total_steps
  ,output logic [31:0]            stat_requests
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [STEP_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic                  overflow_q, overflow_d;
  logic                  result_q, result_d;

  logic push_req, push_ok, pop, full, empty, ovf_evt, resp_err;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    push_req = (step != '0);
    host_req_valid = !empty && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && !result_q;
    host_req_step  = mem_q[rd_ptr_q];
    pop      = host_req_valid && host_req_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok  = push_req && (!full || pop);
    ovf_evt  = push_req && full && !pop;
    resp_err = host_resp_valid && (host_resp_fail || (outstanding_q == '0));
  end

  always_comb begin
    wr_ptr_d      = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    overflow_d    = overflow_q || ovf_evt;
    result_d      = result_q || overflow_q || ovf_evt || resp_err;
    outstanding_d = outstanding_q;
    if (pop && !host_resp_valid)
      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!pop && host_resp_valid && (outstanding_q != '0))
      outstanding_d = outstanding_q - OUT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
      result_q      <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
      result_q      <= result_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= step;
  end

  assign simv_result = result_q;
  assign fifo_count  = count_q;

`ifdef GFIFO_STAT_EN
  logic [63:0] total_q, total_d;
  logic [31:0] reqs_q, reqs_d;

  always_comb begin
    total_d = push_ok ? total_q + 64'(step) : total_q;
    reqs_d  = pop ? reqs_q + 32'd1 : reqs_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      total_q <= '0;
      reqs_q  <= '0;
    end else begin
      total_q <= total_d;
      reqs_q  <= reqs_d;
    end
  end

  assign stat_total_steps = total_q;
  assign stat_requests    = reqs_q;
`endif

endmodule

// File: tb/tb_gfifo_control.sv
// Scoreboard bench for gfifo_control: stimulus queues expected head values,
// a negedge monitor checks every accepted request against them.
module tb_gfifo_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] step;
  logic       simv_result;
  logic       host_req_valid;
  logic [7:0] host_req_step;
  logic       host_req_ready;
  logic       host_resp_valid;
  logic       host_resp_fail;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  gfifo_control #(.STEP_WIDTH(8), .DEPTH(16), .MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset), .step(step), .simv_result(simv_result),
    .host_req_valid(host_req_valid), .host_req_step(host_req_step),
    .host_req_ready(host_req_ready), .host_resp_valid(host_resp_valid),
    .host_resp_fail(host_resp_fail), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_step(input logic [7:0] v, input bit expect_q);
    step = v;
    if (expect_q) exp_q.push_back(v);
    tick();
  endtask

  // Monitor: every accepted request must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && host_req_valid === 1'b1 && host_req_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got step %0h with empty scoreboard", host_req_step);
      end else begin
        chk("req_step", 32'(host_req_step), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; step = 8'd5; host_req_ready = 1'b0;
    host_resp_valid = 1'b0; host_resp_fail = 1'b0;

    // Reset held with a nonzero step: nothing may be queued or offered.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_result", 32'(simv_result), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_valid", 32'(host_req_valid), 32'd0);
    end

    // Single step, popped, then a passing verdict.
    reset = 1'b1; host_req_ready = 1'b1;
    push_step(8'd3, 1'b1);
    step = 8'd0;
    chk("single_valid", 32'(host_req_valid), 32'd1);
    chk("single_step", 32'(host_req_step), 32'd3);
    chk("single_count", 32'(fifo_count), 32'd1);
    tick();
    chk("single_drained", 32'(fifo_count), 32'd0);
    chk("single_valid_off", 32'(host_req_valid), 32'd0);
    host_resp_valid = 1'b1;
    tick();
    host_resp_valid = 1'b0;
    chk("single_pass", 32'(simv_result), 32'd0);

    // Backpressure fills the FIFO; a 17th step overflows.
    host_req_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push_step(8'(i), 1'b1);
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_result_clear", 32'(simv_result), 32'd0);
    push_step(8'd9, 1'b0);
    step = 8'd0;
    chk("ovf_result", 32'(simv_result), 32'd1);
    chk("ovf_valid", 32'(host_req_valid), 32'd0);
    chk("ovf_count", 32'(fifo_count), 32'd16);
    reset = 1'b0; exp_q.delete();
    tick(); tick();
    reset = 1'b1;
    chk("ovf_reset_result", 32'(simv_result), 32'd0);

    // Outstanding limit: six queued, only four accepted without responses.
    for (int i = 0; i < 6; i++) push_step(8'(10 + i), 1'b1);
    step = 8'd0; host_req_ready = 1'b1;
    repeat (6) tick();
    chk("lim_count", 32'(fifo_count), 32'd2);
    chk("lim_valid", 32'(host_req_valid), 32'd0);
    host_resp_valid = 1'b1;
    tick();
    host_resp_valid = 1'b0;
    chk("lim_valid_again", 32'(host_req_valid), 32'd1);
    chk("lim_head", 32'(host_req_step), 32'd14);
    tick();
    chk("lim_count_after", 32'(fifo_count), 32'd1);
    chk("lim_blocked", 32'(host_req_valid), 32'd0);

    // Failing verdict is sticky until reset.
    host_resp_valid = 1'b1; host_resp_fail = 1'b1;
    tick();
    host_resp_valid = 1'b0; host_resp_fail = 1'b0;
    chk("fail_result", 32'(simv_result), 32'd1);
    chk("fail_valid", 32'(host_req_valid), 32'd0);
    repeat (3) tick();
    chk("fail_sticky", 32'(simv_result), 32'd1);
    chk("fail_count_kept", 32'(fifo_count), 32'd1);
    reset = 1'b0; exp_q.delete();
    tick();
    reset = 1'b1;
    chk("fail_cleared", 32'(simv_result), 32'd0);
    chk("fail_cleared_count", 32'(fifo_count), 32'd0);

    // Response with nothing outstanding is a protocol error.
    host_resp_valid = 1'b1;
    tick();
    host_resp_valid = 1'b0;
    chk("proto_err", 32'(simv_result), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("proto_cleared", 32'(simv_result), 32'd0);

    // Full FIFO with simultaneous push and pop: no overflow, order preserved.
    host_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_step(8'(21 + i), 1'b1);
    chk("sim_full", 32'(fifo_count), 32'd16);
    host_req_ready = 1'b1;
    push_step(8'd7, 1'b1);
    step = 8'd0;
    chk("sim_no_ovf", 32'(simv_result), 32'd0);
    chk("sim_count", 32'(fifo_count), 32'd16);
    host_resp_valid = 1'b1;
    repeat (17) tick();
    host_resp_valid = 1'b0; host_req_ready = 1'b0;
    chk("sim_drained", 32'(fifo_count), 32'd0);
    chk("sim_result", 32'(simv_result), 32'd0);
    chk("sim_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
